// File: rtl/vecmac_pkg.sv
// vecmac_pkg: shared widths, FSM state encoding and lane-count legality
// check for the vecmac_lane_mult upstream stage.
//   W_OP    operand width (unsigned)
//   W_PROD  product width (2*W_OP)
//   W_OUT   partial_sum width
//   MAXL    physical lane count
//   W_LANES width of the lanes_i / lanes_o fields
package vecmac_pkg;

  localparam int W_OP    = 8;
  localparam int W_PROD  = 2 * W_OP;
  localparam int W_OUT   = 20;
  localparam int MAXL    = 16;
  localparam int W_LANES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Only power-of-two lane counts up to MAXL are supported.
  function automatic logic lanes_legal(input logic [W_LANES-1:0] lanes);
    case (lanes)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vecmac_adder_tree.sv
// vecmac_adder_tree: reduces 16 unsigned W_PROD-bit products to one W_OUT-bit
// sum. The output sum is registered; valid/last travel alongside the data.
// Optional macro VECMAC_PIPE3_EN adds a register after the 4-lane sums,
// giving two register stages through the tree instead of one.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_valid      input beat valid
//   i_last       input beat is the last of its vector
//   i_prod       16 packed products, lane k at [16k+15:16k]
//   o_valid      sum valid
//   o_last       sum belongs to the last beat
//   o_sum        reduced sum (0 when o_valid is low)
module vecmac_adder_tree
  import vecmac_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic                   i_last,
  input  logic [MAXL*W_PROD-1:0] i_prod,
  output logic                   o_valid,
  output logic                   o_last,
  output logic [W_OUT-1:0]       o_sum
);

  // Four 16-bit products need two extra bits.
  localparam int W_QUAD = W_PROD + 2;

  logic [W_QUAD-1:0] w_quad   [4];
  logic [W_QUAD-1:0] w_quad_s [4];
  logic              w_mid_valid;
  logic              w_mid_last;
  logic [W_OUT-1:0]  w_total;
  logic              r_valid;
  logic              r_last;
  logic [W_OUT-1:0]  r_sum;

  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    assign w_quad[gi] = W_QUAD'(i_prod[(4*gi+0)*W_PROD +: W_PROD])
                      + W_QUAD'(i_prod[(4*gi+1)*W_PROD +: W_PROD])
                      + W_QUAD'(i_prod[(4*gi+2)*W_PROD +: W_PROD])
                      + W_QUAD'(i_prod[(4*gi+3)*W_PROD +: W_PROD]);
`ifdef VECMAC_PIPE3_EN
    logic [W_QUAD-1:0] r_quad;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_quad <= '0;
      else        r_quad <= w_quad[gi];
    end
    assign w_quad_s[gi] = r_quad;
`else
    assign w_quad_s[gi] = w_quad[gi];
`endif
  end

`ifdef VECMAC_PIPE3_EN
  logic r_mid_valid;
  logic r_mid_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mid_valid <= 1'b0;
      r_mid_last  <= 1'b0;
    end else begin
      r_mid_valid <= i_valid;
      r_mid_last  <= i_valid & i_last;
    end
  end
  assign w_mid_valid = r_mid_valid;
  assign w_mid_last  = r_mid_last;
`else
  assign w_mid_valid = i_valid;
  assign w_mid_last  = i_last;
`endif

  assign w_total = W_OUT'(w_quad_s[0]) + W_OUT'(w_quad_s[1])
                 + W_OUT'(w_quad_s[2]) + W_OUT'(w_quad_s[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_valid <= w_mid_valid;
      r_last  <= w_mid_valid & w_mid_last;
      r_sum   <= w_mid_valid ? w_total : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_sum   = r_sum;

endmodule

// File: rtl/vecmac_lane_mult.sv
// vecmac_lane_mult: lane-wise 8x8 multiply of up to 16 operand pairs per beat,
// masking of unused and tail lanes, and reduction to one partial_sum per beat.
// Latency from accepted beat to ps_valid is 2 cycles (3 with VECMAC_PIPE3_EN).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, lanes_i    begin a vector with the given lane count (IDLE only)
//   a_valid, a_ready  operand beat handshake (a_ready high only in RUN)
//   a_data, b_data    packed operands, lane k at [8k+7:8k]
//   ps_valid          partial_sum valid
//   partial_sum       sum of the beat's active products
//   ps_last           final beat of the vector
//   lanes_o           latched lane count
//   busy              high in RUN or DRAIN
//   cfg_err           one-cycle pulse after a start with illegal lanes_i
module vecmac_lane_mult
  import vecmac_pkg::*;
#(
  parameter int ELEMS = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4:0]           lanes_i,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [MAXL*W_OP-1:0] a_data,
  input  logic [MAXL*W_OP-1:0] b_data,
  output logic                 ps_valid,
  output logic [W_OUT-1:0]     partial_sum,
  output logic                 ps_last,
  output logic [4:0]           lanes_o,
  output logic                 busy,
  output logic                 cfg_err
);

  // Counter is wide enough to hold ELEMS plus one overshooting beat.
  localparam int CW = $clog2(ELEMS + MAXL) + 1;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [W_LANES-1:0]     r_lanes;
  logic [CW-1:0]          r_elem_cnt;
  logic                   r_cfg_err;
  logic                   w_start_ok;
  logic                   w_accept;
  logic [CW-1:0]          w_cnt_next;
  logic                   w_last_beat;
  logic [CW-1:0]          w_remain;
  logic [W_LANES-1:0]     w_active;
  logic [MAXL*W_PROD-1:0] w_prod;
  logic                   r_s1_valid;
  logic                   r_s1_last;
  logic [MAXL*W_PROD-1:0] r_s1_prod;
  logic                   w_ps_valid;
  logic                   w_ps_last;
  logic [W_OUT-1:0]       w_ps_sum;

  assign w_start_ok  = (r_state == IDLE) && start && lanes_legal(lanes_i);
  assign w_accept    = a_valid && (r_state == RUN);
  assign w_cnt_next  = r_elem_cnt + CW'(r_lanes);
  assign w_last_beat = (w_cnt_next >= CW'(ELEMS));
  assign w_remain    = CW'(ELEMS) - r_elem_cnt;
  // Only the tail beat has fewer remaining elements than lanes, so the
  // truncation to W_LANES bits happens only when the value is below 16.
  assign w_active    = (w_remain < CW'(r_lanes)) ? w_remain[W_LANES-1:0] : r_lanes;

  for (genvar gi = 0; gi < MAXL; gi++) begin : g_lane
    localparam logic [W_LANES-1:0] LANE_IDX = W_LANES'(gi);
    assign w_prod[gi*W_PROD +: W_PROD] =
      (LANE_IDX < w_active)
        ? W_PROD'(a_data[gi*W_OP +: W_OP]) * W_PROD'(b_data[gi*W_OP +: W_OP])
        : '0;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_next = RUN;
      RUN:     if (w_accept && w_last_beat) w_state_next = DRAIN;
      DRAIN:   if (w_ps_valid && w_ps_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lanes    <= '0;
      r_elem_cnt <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cfg_err <= (r_state == IDLE) && start && !lanes_legal(lanes_i);
      if (w_start_ok) begin
        r_lanes    <= lanes_i;
        r_elem_cnt <= '0;
      end else if (w_accept) begin
        r_elem_cnt <= w_cnt_next;
      end
    end
  end

  // Stage 1: masked products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_prod  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && w_last_beat;
      r_s1_prod  <= w_accept ? w_prod : '0;
    end
  end

  vecmac_adder_tree u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_s1_valid),
    .i_last  (r_s1_last),
    .i_prod  (r_s1_prod),
    .o_valid (w_ps_valid),
    .o_last  (w_ps_last),
    .o_sum   (w_ps_sum)
  );

  assign a_ready     = (r_state == RUN);
  assign busy        = (r_state != IDLE);
  assign lanes_o     = r_lanes;
  assign cfg_err     = r_cfg_err;
  assign ps_valid    = w_ps_valid;
  assign partial_sum = w_ps_valid ? w_ps_sum : '0;
  assign ps_last     = w_ps_valid && w_ps_last;

endmodule

// File: tb/tb_vecmac_lane_mult.sv
// tb_vecmac_lane_mult: directed, table-driven bench for vecmac_lane_mult.
// Honors VECMAC_PIPE3_EN for the expected latency.
module tb_vecmac_lane_mult;
  import vecmac_pkg::*;

`ifdef VECMAC_PIPE3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int ELEMS = 1000;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [4:0]           lanes_i;
  logic                 a_valid;
  logic                 a_ready;
  logic [MAXL*W_OP-1:0] a_data;
  logic [MAXL*W_OP-1:0] b_data;
  logic                 ps_valid;
  logic [W_OUT-1:0]     partial_sum;
  logic                 ps_last;
  logic [4:0]           lanes_o;
  logic                 busy;
  logic                 cfg_err;

  vecmac_lane_mult #(.ELEMS(ELEMS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .lanes_i     (lanes_i),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_data      (a_data),
    .b_data      (b_data),
    .ps_valid    (ps_valid),
    .partial_sum (partial_sum),
    .ps_last     (ps_last),
    .lanes_o     (lanes_o),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     lanes;
    int     a;
    int     b;
    bit     bubble;
    int     beats;
    longint full;
    longint tail;
    longint total;
  } vec_t;

  vec_t tbl [5];

  int     total_cnt = 0;
  int     bad_cnt   = 0;

  // Output monitor state, all owned by the single stimulus process.
  int     cyc;
  int     acc_q [$];
  int     m_exp_beats;
  longint m_full, m_tail;
  int     m_beats, m_val_bad, m_lat_bad, m_zero_bad;
  int     m_last_cnt, m_last_idx, m_cfg_cnt, m_busy_cnt, m_ready_cnt;
  int     m_busy_after;
  bit     m_prev_last;
  longint m_sum;

  task automatic check(input string name, input longint got, input longint exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_mon(input int beats, input longint full, input longint tail);
    acc_q.delete();
    m_exp_beats = beats; m_full = full; m_tail = tail;
    m_beats = 0; m_val_bad = 0; m_lat_bad = 0; m_zero_bad = 0;
    m_last_cnt = 0; m_last_idx = 0; m_cfg_cnt = 0; m_busy_cnt = 0;
    m_ready_cnt = 0; m_busy_after = 99; m_prev_last = 0; m_sum = 0;
  endtask

  // Advance to the next falling edge and sample every output there.
  task automatic step();
    longint exp;
    int     t;
    @(negedge clk);
    cyc++;
    if (m_prev_last) begin
      m_busy_after = int'(busy);
      m_prev_last  = 0;
    end
    if (cfg_err) m_cfg_cnt++;
    if (busy)    m_busy_cnt++;
    if (a_ready) m_ready_cnt++;
    if (ps_valid) begin
      m_beats++;
      m_sum += longint'(partial_sum);
      exp = (m_beats == m_exp_beats) ? m_tail : m_full;
      if (longint'(partial_sum) != exp) m_val_bad++;
      if (acc_q.size() == 0) m_lat_bad++;
      else begin
        t = acc_q.pop_front();
        if (cyc - t != LAT) m_lat_bad++;
      end
      if (ps_last) begin
        m_last_cnt++;
        m_last_idx  = m_beats;
        m_prev_last = 1;
      end
    end else if (partial_sum != '0 || ps_last) begin
      m_zero_bad++;
    end
  endtask

  // Drive one beat; lanes at or above 'lanes' carry random garbage.
  task automatic drive(input bit valid, input int lanes, input int a, input int b,
                       output bit accepted);
    a_valid = valid;
    for (int k = 0; k < MAXL; k++) begin
      a_data[k*W_OP +: W_OP] = (k < lanes) ? 8'(a) : 8'($urandom);
      b_data[k*W_OP +: W_OP] = (k < lanes) ? 8'(b) : 8'($urandom);
    end
    accepted = valid && a_ready;
    if (accepted) acc_q.push_back(cyc);
  endtask

  task automatic run_row(input int idx, input vec_t v, input int inject_at);
    int sent, guard;
    bit tog, acc;
    clear_mon(v.beats, v.full, v.tail);
    start = 1'b1; lanes_i = 5'(v.lanes);
    step();
    start = 1'b0;
    sent = 0; guard = 0; tog = 1'b1;
    while (sent < v.beats && guard < 3 * v.beats + 20) begin
      if (inject_at >= 0 && sent == inject_at) begin
        start = 1'b1; lanes_i = 5'd16;
      end else begin
        start = 1'b0;
      end
      drive(v.bubble ? tog : 1'b1, v.lanes, v.a, v.b, acc);
      if (acc) sent++;
      tog = ~tog;
      step();
      guard++;
    end
    start = 1'b0; a_valid = 1'b0;
    guard = 0;
    while (m_last_cnt == 0 && guard < 20) begin
      step();
      guard++;
    end
    step(); step();
    check($sformatf("r%0d_sent", idx), sent, v.beats);
    check($sformatf("r%0d_beats", idx), m_beats, v.beats);
    check($sformatf("r%0d_sum", idx), m_sum, v.total);
    check($sformatf("r%0d_value_errs", idx), m_val_bad, 0);
    check($sformatf("r%0d_latency_errs", idx), m_lat_bad, 0);
    check($sformatf("r%0d_idle_nonzero", idx), m_zero_bad, 0);
    check($sformatf("r%0d_last_count", idx), m_last_cnt, 1);
    check($sformatf("r%0d_last_pos", idx), m_last_idx, v.beats);
    check($sformatf("r%0d_busy_after_last", idx), m_busy_after, 0);
    check($sformatf("r%0d_lanes_o", idx), lanes_o, v.lanes);
  endtask

  initial begin
    bit acc;

    //          lanes a    b    bub beats full     tail    total
    tbl[0] = '{16,   255, 255, 0, 63,   1040400, 520200, 65025000};
    tbl[1] = '{1,    1,   1,   0, 1000, 1,       1,      1000};
    tbl[2] = '{4,    2,   3,   1, 250,  24,      24,     6000};
    tbl[3] = '{8,    10,  20,  0, 125,  1600,    1600,   200000};
    tbl[4] = '{2,    7,   9,   0, 500,  126,     126,    63000};

    cyc = 0;
    rst_n = 1'b0; start = 1'b0; lanes_i = '0; a_valid = 1'b0;
    a_data = '0; b_data = '0;
    clear_mon(0, 0, 0);
    step(); step();
    check("rst_a_ready", a_ready, 0);
    check("rst_ps_valid", ps_valid, 0);
    check("rst_partial_sum", partial_sum, 0);
    check("rst_ps_last", ps_last, 0);
    check("rst_lanes_o", lanes_o, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_row(i, tbl[i], -1);

    // Illegal lane counts: one cfg_err pulse each, nothing else moves.
    clear_mon(0, 0, 0);
    start = 1'b1; lanes_i = 5'd3;
    step();
    start = 1'b0;
    step(); step(); step();
    start = 1'b1; lanes_i = 5'd0;
    step();
    start = 1'b0;
    step(); step(); step();
    check("cfg_err_pulses", m_cfg_cnt, 2);
    check("cfg_ready_cycles", m_ready_cnt, 0);
    check("cfg_busy_cycles", m_busy_cnt, 0);
    check("cfg_ps_beats", m_beats, 0);
    check("cfg_lanes_o_kept", lanes_o, 8);

    // start during RUN (requesting 16 lanes) must be ignored.
    run_row(5, tbl[2], 50);

    // Reset at beat 100 of a lanes=8 vector.
    clear_mon(125, 1600, 1600);
    start = 1'b1; lanes_i = 5'd8;
    step();
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      drive(1'b1, 8, 10, 20, acc);
      step();
    end
    rst_n = 1'b0;
    a_valid = 1'b0;
    step();
    check("mid_rst_ps_valid", ps_valid, 0);
    check("mid_rst_partial_sum", partial_sum, 0);
    check("mid_rst_a_ready", a_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_lanes_o", lanes_o, 0);
    rst_n = 1'b1;
    clear_mon(0, 0, 0);
    for (int n = 0; n < 6; n++) step();
    check("post_rst_no_ps", m_beats, 0);
    check("post_rst_busy", m_busy_cnt, 0);

    run_row(4, tbl[4], -1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
